// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and transmitter states for mmio_uart_tx
package uart_pkg;
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIVISOR = 2'd2;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_IRQ_EN = 4;
  localparam int ST_COUNT = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with occupancy count; pushes when full and pops when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO, STATUS and DIVISOR registers
// Define UART_TX_IRQ_EN to build the level interrupt and the writable STATUS irq_en bit.
module mmio_uart_tx import uart_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int FIFO_DEPTH = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd1042
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic        core_wr_ena,
  input  logic [31:0] core_wr_data,
  output logic [31:0] core_rd_data,
  output logic        hit,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_tx_state_t state, state_n;
  logic [15:0] divisor, bit_div, timer;
  logic [7:0] shift, fifo_dout;
  logic [2:0] bit_cnt;
  logic [CW-1:0] count;
  logic [31:0] status;
  logic [1:0] sel;
  logic full, empty, busy, overflow, irq_en, win, push, pop, tick, tx_n, st_wr, div_wr, unused;
  assign win = core_addr[31:4] == BASE_ADDR[31:4];
  assign sel = core_addr[3:2];
  assign push = core_wr_ena & win & (sel == UART_TXDATA);
  assign st_wr = core_wr_ena & win & (sel == UART_STATUS);
  assign div_wr = core_wr_ena & win & (sel == UART_DIVISOR);
  assign busy = state != IDLE;
  assign tick = timer == bit_div - 16'd1;
  assign unused = ^{core_addr[1:0], core_wr_data[31:16]};
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(core_wr_data[7:0]),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    pop = 1'b0;
    tx_n = 1'b1;
    case (state)
      IDLE: begin
        pop = ~empty;
        state_n = empty ? IDLE : START;
      end
      START: begin
        tx_n = 1'b0;
        state_n = tick ? DATA : START;
      end
      DATA: begin
        tx_n = shift[0];
        state_n = (tick && bit_cnt == 3'd7) ? STOP : DATA;
      end
      STOP: begin
        pop = tick & ~empty;
        state_n = tick ? (empty ? IDLE : START) : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
  // tx is registered from the current state, so each level appears one edge after the state enters it
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx <= 1'b1;
      timer <= '0;
      bit_cnt <= '0;
      shift <= '0;
      bit_div <= DEFAULT_DIVISOR;
    end else begin
      tx <= tx_n;
      if (pop) begin
        shift <= fifo_dout;
        bit_div <= divisor;
        timer <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        timer <= tick ? '0 : timer + 16'd1;
        if (tick && state == DATA) begin
          shift <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = busy;
    status[ST_OVF] = overflow;
    status[ST_IRQ_EN] = irq_en;
    status[ST_COUNT +: 8] = 8'(count);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit <= 1'b0;
      core_rd_data <= '0;
      overflow <= 1'b0;
      divisor <= DEFAULT_DIVISOR;
    end else begin
      hit <= win;
      core_rd_data <= !win ? '0 : sel == UART_STATUS ? status : sel == UART_DIVISOR ? {16'h0, divisor} : '0;
      if (push & full) overflow <= 1'b1;
      else if (st_wr & core_wr_data[ST_OVF]) overflow <= 1'b0;
      if (div_wr) divisor <= core_wr_data[15:0] == 16'h0 ? 16'h1 : core_wr_data[15:0];
    end
  end
`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (st_wr) irq_en <= core_wr_data[ST_IRQ_EN];
      irq <= irq_en & (empty & ~busy | overflow);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq = 1'b0;
`endif
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the multicycle core's data-memory bus as a peripheral behind the MMU. The core writes bytes into a small TX FIFO and polls status; the block serialises them as 8N1 frames on a single `tx` pin. The MMU decodes nothing inside the window: it ORs `core_rd_data` from this block into its read mux and forwards the bus unchanged.

## Interface
- `BASE_ADDR`, 32'h0000_3000: word-aligned base of the 16-byte register window.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..64.
- `DEFAULT_DIVISOR`, 1042: reset value of DIVISOR; 115200 baud at 120 MHz.
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-low reset.
- `core_addr`  in  32: byte address from the core.
- `core_wr_ena`  in  1: write strobe, one cycle per store.
- `core_wr_data`  in  32: store data.
- `core_rd_data`  out  32: registered read data; all zeros when the address is outside the window.
- `hit`  out  1: registered; high when the previous-cycle address was inside the window.
- `tx`  out  1: serial output, idle high.
- `irq`  out  1: level interrupt; see Configuration.

## Operation
- Window decode: `core_addr[31:4] == BASE_ADDR[31:4]`. Register selected by `core_addr[3:2]`; `core_addr[1:0]` ignored.
- 0x0 TXDATA:
  - Write pushes `core_wr_data[7:0]`.
  - Reads return 0.
- 0x4 STATUS:
  - Read-only bits: [0] full, [1] empty, [2] busy (FSM not IDLE), [15:8] FIFO count.
  - [3] overflow: sticky; writing 1 to bit 3 clears it.
  - [4] irq_en: R/W, reset 0.
- 0x8 DIVISOR:
  - R/W [15:0]; upper bits read 0.
  - A written value of 0 is stored as 1.
- 0xC: reserved; reads 0, writes ignored.
- Push when full: byte dropped, overflow set. Full is sampled before any same-cycle pop, so the byte is dropped even if a pop happens on the same edge.
- FSM states:
  - IDLE → START when FIFO not empty: pop, load shift register, latch DIVISOR into `bit_div`, zero the bit counter.
  - START: `tx`=0 for `bit_div` cycles, then DATA.
  - DATA: 8 bits LSB first, each held `bit_div` cycles, then STOP.
  - STOP: `tx`=1 for `bit_div` cycles. At the end, if FIFO not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- DIVISOR writes during a frame take effect at the next frame start.
- FIFO count arithmetic is $clog2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reads:
  - `core_rd_data` and `hit` are registered, valid one cycle after the address is presented, to match MMU read latency.
  - A STATUS read reflects state before any same-cycle write.
- Writes take effect at the clock edge where `core_wr_ena` is high.
- A push is visible in STATUS count on the next cycle.
- Latency from TXDATA write (edge N) with the FSM idle:
  - Pop at edge N+1.
  - `tx` falls after edge N+2.
- Frame length is exactly 10×`bit_div` cycles. Back-to-back frames are contiguous.
- Reset values: `tx`=1, `core_rd_data`=0, `hit`=0, `irq`=0, FIFO empty, overflow=0, irq_en=0, DIVISOR=DEFAULT_DIVISOR, FSM IDLE.
- Reset mid-frame: the frame is truncated and `tx` returns high on the next edge. FIFO contents are discarded.

## Configuration
- `UART_TX_IRQ_EN` defined:
  - `irq` = irq_en & (empty & ~busy | overflow), registered.
  - STATUS[4] is writable.
- `UART_TX_IRQ_EN` undefined:
  - `irq` tied 0.
  - STATUS[4] reads 0 and writes to it are ignored.
  - No irq logic is synthesised.

## Structure
- `uart_pkg` holds:
  - Register offset localparams (`UART_TXDATA`=0, `UART_STATUS`=1, `UART_DIVISOR`=2, as word indices).
  - STATUS bit-position localparams.
  - `uart_tx_state_t` enum {IDLE, START, DATA, STOP}.
- One sub-module, `sync_fifo` (WIDTH, DEPTH), with push/pop/full/empty/count and the same reset convention. The FSM, bit timer and register file live in `mmio_uart_tx`.

## Test plan
- Reset, then read STATUS and DIVISOR → 32'h0000_0002 and 1042; `tx`=1 throughout.
- DIVISOR=4, write TXDATA=0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; frame is 40 cycles; busy clears after it.
- DIVISOR=2, write 0x00, 0xFF, 0xA5 back-to-back → three contiguous frames, 60 cycles total, no idle gap; count reads 2, then 1, then 0.
- With DIVISOR=100, write 9 bytes fast → the first pops immediately and the remaining 8 fill the FIFO. A 10th write is dropped and sets overflow. Writing 0x8 to STATUS clears overflow; the dropped byte is never sent.
- Reset asserted mid-DATA → `tx`=1 next cycle, STATUS empty, no further frames.
- With `UART_TX_IRQ_EN`, irq_en=1 → `irq` high when idle and empty, low while a frame is queued or in flight. Without the macro, `irq` stays 0 and STATUS[4] stays 0.
